// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB command master.
//   state_e   : FSM encoding (IDLE=0, SETUP=1, ACCESS=2, RESP=3)
//   cmd_width : bit width of a packed {write, addr, wdata} command word
package apb_master_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    function automatic int cmd_width(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous FIFO with flop-based storage.
//   clk_i, rst_i     : clock, synchronous active-high reset (flushes FIFO)
//   push_i / din_i   : write request and data (ignored when full)
//   pop_i / dout_o   : read request (ignored when empty), head-of-queue data
//   full_o, empty_o  : status flags from the registered count
//   count_o          : current number of stored entries
module apb_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A push is refused when full even if a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally since DEPTH is a power of two.
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk_i) begin
            if (do_push && (wr_ptr_q == PW'(gi))) begin
                mem_q[gi] <= din_i;
            end
        end
    end

endmodule

// File: rtl/apb_cmd_master.sv
// APB3 initiator: queues valid/ready commands and issues them one at a time
// as APB transfers, returning one response per command in order.
//   clk_i, rst_i                : clock, synchronous active-high reset
//   cmd_*                       : command stream (write flag, address, wdata)
//   rsp_*                       : response stream (write echo, rdata, timeout)
//   apb_*_m                     : APB3 master-side bus signals
//   busy_o                      : commands queued or a transfer in progress
module apb_cmd_master
    import apb_master_pkg::*;
#(
    parameter int BUS_AW         = 6,
    parameter int BUS_DW         = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_vld_i,
    output logic              cmd_rdy_o,
    input  logic              cmd_write_i,
    input  logic [BUS_AW-1:0] cmd_addr_i,
    input  logic [BUS_DW-1:0] cmd_wdata_i,
    output logic              rsp_vld_o,
    input  logic              rsp_rdy_i,
    output logic              rsp_write_o,
    output logic [BUS_DW-1:0] rsp_rdata_o,
    output logic              rsp_timeout_o,
    output logic [BUS_AW-1:0] apb_paddr_m,
    output logic              apb_pwrite_m,
    output logic              apb_psel_m,
    output logic              apb_penable_m,
    output logic [BUS_DW-1:0] apb_pwdata_m,
    input  logic [BUS_DW-1:0] apb_prdata_m,
    input  logic              apb_pready_m,
    output logic              busy_o
);

    localparam int CMD_W = cmd_width(BUS_AW, BUS_DW);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic             cmd_push, fifo_pop, fifo_full, fifo_empty;
    logic [CMD_W-1:0] fifo_dout;
    logic [FCW-1:0]   fifo_count, fifo_level_next;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic              psel_q, psel_d, penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [BUS_AW-1:0] paddr_q, paddr_d;
    logic [BUS_DW-1:0] pwdata_q, pwdata_d;
    logic              rsp_vld_q, rsp_vld_d, rsp_write_q, rsp_write_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [BUS_DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              busy_q, busy_d;

    assign cmd_rdy_o = !fifo_full;
    assign cmd_push  = cmd_vld_i && !fifo_full;

    apb_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cmd_push),
        .din_i   ({cmd_write_i, cmd_addr_i, cmd_wdata_i}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Occupancy after this edge; lets busy_o be a plain register.
    assign fifo_level_next = fifo_count + FCW'(cmd_push) - FCW'(fifo_pop);

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_vld_d     = rsp_vld_q;
        rsp_write_d   = rsp_write_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        fifo_pop      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    {pwrite_d, paddr_d, pwdata_d} = fifo_dout;
                    wait_d  = '0;
                    psel_d  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // PREADY wins over the timeout in the last allowed cycle.
                if (apb_pready_m) begin
                    rsp_rdata_d   = pwrite_q ? '0 : apb_prdata_m;
                    rsp_timeout_d = 1'b0;
                    rsp_write_d   = pwrite_q;
                    rsp_vld_d     = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = ST_RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (wait_q == WAIT_LAST)) begin
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                    rsp_write_d   = pwrite_q;
                    rsp_vld_d     = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = ST_RESP;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_rdy_i) begin
                    rsp_vld_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE) || (fifo_level_next != '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            wait_q        <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_vld_q     <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_vld_q     <= rsp_vld_d;
            rsp_write_q   <= rsp_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign apb_psel_m    = psel_q;
    assign apb_penable_m = penable_q;
    assign apb_pwrite_m  = pwrite_q;
    assign apb_paddr_m   = paddr_q;
    assign apb_pwdata_m  = pwdata_q;
    assign rsp_vld_o     = rsp_vld_q;
    assign rsp_write_o   = rsp_write_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed testbench for apb_cmd_master (TIMEOUT_CYCLES = 8).
module tb_apb_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_vld, cmd_rdy, cmd_write;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_vld, rsp_rdy, rsp_write, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [5:0]  paddr;
    logic        pwrite, psel, penable, pready, busy;
    logic [31:0] pwdata, prdata, prdata_v;
    logic        use_model;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Simple slave: either a fixed value or an address-derived pattern.
    assign prdata = use_model ? (32'hC0DE_0000 | {26'd0, paddr}) : prdata_v;

    apb_cmd_master #(
        .BUS_AW         (6),
        .BUS_DW         (32),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cmd_vld_i     (cmd_vld),
        .cmd_rdy_o     (cmd_rdy),
        .cmd_write_i   (cmd_write),
        .cmd_addr_i    (cmd_addr),
        .cmd_wdata_i   (cmd_wdata),
        .rsp_vld_o     (rsp_vld),
        .rsp_rdy_i     (rsp_rdy),
        .rsp_write_o   (rsp_write),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_timeout_o (rsp_timeout),
        .apb_paddr_m   (paddr),
        .apb_pwrite_m  (pwrite),
        .apb_psel_m    (psel),
        .apb_penable_m (penable),
        .apb_pwdata_m  (pwdata),
        .apb_prdata_m  (prdata),
        .apb_pready_m  (pready),
        .busy_o        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic show_rsp();
        $display("[TB] rsp write=%0b rdata=%08h timeout=%0b", rsp_write, rsp_rdata, rsp_timeout);
    endtask

    initial begin
        int got;
        int cyc;
        int last;

        rst = 1'b1; cmd_vld = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_rdy = 1'b0; pready = 1'b1; prdata_v = '0; use_model = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_cmd_rdy", cmd_rdy, 1);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        chk("idle_psel", psel, 0);

        // Single write, PREADY=1: response at T+4
        cmd_vld = 1'b1; cmd_write = 1'b1; cmd_addr = 6'h04; cmd_wdata = 32'hDEAD_BEEF;
        tick();                               // T+1
        cmd_vld = 1'b0;
        chk("wr_t1_psel", psel, 0);
        chk("wr_t1_busy", busy, 1);
        tick();                               // T+2 SETUP
        chk("wr_setup_psel", psel, 1);
        chk("wr_setup_penable", penable, 0);
        chk("wr_setup_paddr", paddr, 6'h04);
        chk("wr_setup_pwrite", pwrite, 1);
        chk("wr_setup_pwdata", pwdata, 32'hDEAD_BEEF);
        tick();                               // T+3 ACCESS
        chk("wr_access_psel", psel, 1);
        chk("wr_access_penable", penable, 1);
        chk("wr_access_pwdata", pwdata, 32'hDEAD_BEEF);
        chk("wr_access_rsp_vld", rsp_vld, 0);
        tick();                               // T+4 RESP
        chk("wr_rsp_vld", rsp_vld, 1);
        chk("wr_rsp_write", rsp_write, 1);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        chk("wr_rsp_timeout", rsp_timeout, 0);
        chk("wr_rsp_psel", psel, 0);
        show_rsp();
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
        chk("wr_done_vld", rsp_vld, 0);
        chk("wr_done_busy", busy, 0);

        // Read with 3 wait states
        pready = 1'b0; prdata_v = 32'h1234_5678;
        cmd_vld = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h10; cmd_wdata = 32'hFFFF_FFFF;
        tick();
        cmd_vld = 1'b0;
        tick();                               // SETUP
        chk("rd_setup_pwrite", pwrite, 0);
        chk("rd_setup_paddr", paddr, 6'h10);
        for (int i = 0; i < 4; i++) begin
            tick();                           // ACCESS cycles 1..4
            chk("rd_access_penable", penable, 1);
            chk("rd_access_rsp_vld", rsp_vld, 0);
        end
        pready = 1'b1;                        // ready in 4th ACCESS cycle
        tick();
        chk("rd_rsp_vld", rsp_vld, 1);
        chk("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
        chk("rd_rsp_write", rsp_write, 0);
        chk("rd_rsp_timeout", rsp_timeout, 0);
        show_rsp();
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;

        // Timeout: PREADY stuck low, ACCESS exactly 8 cycles
        pready = 1'b0; prdata_v = 32'hAAAA_5555;
        cmd_vld = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h08;
        tick();
        cmd_vld = 1'b0;
        tick();                               // SETUP
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("to_access_penable", penable, 1);
            chk("to_access_rsp_vld", rsp_vld, 0);
        end
        tick();
        chk("to_rsp_vld", rsp_vld, 1);
        chk("to_rsp_timeout", rsp_timeout, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        chk("to_rsp_psel", psel, 0);
        show_rsp();
        rsp_rdy = 1'b1;
        pready = 1'b1;
        tick();
        rsp_rdy = 1'b0;

        // Fill FIFO: 5 reads back-to-back with rsp_rdy low
        use_model = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cmd_vld = 1'b1; cmd_write = 1'b0; cmd_addr = 6'(i);
            chk("fill_rdy", cmd_rdy, 1);
            tick();
        end
        cmd_vld = 1'b0;
        chk("fill_full", cmd_rdy, 0);
        chk("fill_first_vld", rsp_vld, 1);
        chk("fill_first_rdata", rsp_rdata, 32'hC0DE_0000);

        // Backpressure: 10 cycles, fields stable, no new SETUP
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_rsp_vld", rsp_vld, 1);
            chk("bp_rsp_rdata", rsp_rdata, 32'hC0DE_0000);
            chk("bp_psel", psel, 0);
            chk("bp_cmd_rdy", cmd_rdy, 0);
        end

        // Release: 5 responses in order, 4 cycles apart
        rsp_rdy = 1'b1;
        got = 0; cyc = 0; last = 0;
        while (got < 5 && cyc < 80) begin
            if (rsp_vld) begin
                chk("order_rdata", rsp_rdata, 32'hC0DE_0000 | got);
                chk("order_timeout", rsp_timeout, 0);
                if (got > 0) chk("order_spacing", cyc - last, 4);
                show_rsp();
                last = cyc;
                got++;
            end
            tick();
            cyc++;
        end
        rsp_rdy = 1'b0;
        chk("fill_rsp_count", got, 5);
        chk("fill_done_rdy", cmd_rdy, 1);
        chk("fill_done_busy", busy, 0);

        // Reset in ACCESS with 2 commands queued
        use_model = 1'b0; pready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmd_vld = 1'b1; cmd_write = 1'b1; cmd_addr = 6'(32 + i); cmd_wdata = 32'(i);
            tick();
        end
        cmd_vld = 1'b0;
        chk("rstx_access_penable", penable, 1);
        chk("rstx_access_busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("rstx_psel", psel, 0);
        chk("rstx_penable", penable, 0);
        chk("rstx_busy", busy, 0);
        chk("rstx_cmd_rdy", cmd_rdy, 1);
        chk("rstx_rsp_vld", rsp_vld, 0);
        rst = 1'b0;
        pready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rstx_no_rsp", rsp_vld, 0);
            chk("rstx_no_psel", psel, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

APB initiator that turns a valid/ready command stream into APB3 transfers. It drives the slave side of `apb_input_buffer_port` (6-bit address, 32-bit data, no PSLVERR). Commands are queued in a small FIFO and issued one at a time, with exactly one transfer on the bus at any moment. Every command yields one response carrying read data and a timeout flag. It sits between the test/control sequencer and the input-buffer APB slave.

## Interface
- `BUS_AW`, 6, APB address width
- `BUS_DW`, 32, APB data width
- `FIFO_DEPTH`, 4, command FIFO entries; power of two, ≥2
- `TIMEOUT_CYCLES`, 255, maximum ACCESS cycles without PREADY; 0 disables the timeout
- `clk_i` in 1, single clock, rising edge
- `rst_i` in 1, reset; synchronous, active-high
- `cmd_vld_i` in 1, command valid
- `cmd_rdy_o` out 1, command ready (FIFO not full)
- `cmd_write_i` in 1, 1 = write, 0 = read
- `cmd_addr_i` in BUS_AW, target address
- `cmd_wdata_i` in BUS_DW, write data; ignored for reads
- `rsp_vld_o` out 1, response valid
- `rsp_rdy_i` in 1, response ready
- `rsp_write_o` out 1, echoes `cmd_write_i`
- `rsp_rdata_o` out BUS_DW, captured PRDATA; 0 for writes and timeouts
- `rsp_timeout_o` out 1, transfer aborted by timeout
- `apb_paddr_m` out BUS_AW, PADDR
- `apb_pwrite_m` out 1, PWRITE
- `apb_psel_m` out 1, PSEL
- `apb_penable_m` out 1, PENABLE
- `apb_pwdata_m` out BUS_DW, PWDATA
- `apb_prdata_m` in BUS_DW, PRDATA
- `apb_pready_m` in 1, PREADY
- `busy_o` out 1, FIFO non-empty or FSM not IDLE

## Operation
- **Push:** a command is pushed when `cmd_vld_i && cmd_rdy_o`.
  - `cmd_rdy_o = !full`, derived from the registered count.
  - No push when full, even if a pop occurs in the same cycle.
- **FSM states:** IDLE, SETUP, ACCESS, RESP.
- **IDLE:** if the FIFO is not empty, pop the head, latch write/addr/wdata, go to SETUP.
- **SETUP:** `psel=1`, `penable=0`. Always go to ACCESS next cycle.
- **ACCESS:** `psel=1`, `penable=1`.
  - If `pready=1`: capture `prdata` for reads (0 for writes), `timeout=0`, go to RESP.
  - Otherwise increment the wait counter.
  - If the counter reaches `TIMEOUT_CYCLES-1` and `pready=0`: `rdata=0`, `timeout=1`, go to RESP.
  - The counter clears on entry to SETUP. It is `$clog2(TIMEOUT_CYCLES+1)` bits wide.
- **RESP:** `psel=0`, `penable=0`, `rsp_vld_o=1`, response fields stable.
  - On `rsp_rdy_i`, go to IDLE.
  - With `rsp_rdy_i` low, RESP holds indefinitely. The FIFO keeps accepting commands until full.
- **Bus stability:** `paddr`/`pwrite`/`pwdata` are stable from SETUP through ACCESS. Outside a transfer they hold their last values.
- **Ordering:** responses are returned in command order.

## Timing
- All outputs are registered.
- **Reset values:** `cmd_rdy_o=1`; everything else 0 (`rsp_*`, `apb_*`, `busy_o`); FIFO empty; FSM in IDLE.
- **Command-to-response latency:** push in cycle T → FIFO visible T+1 → SETUP T+2 → ACCESS T+3 → `rsp_vld_o` in T+4 when PREADY is high in T+3.
- Each PREADY-low cycle in ACCESS adds one cycle of latency.
- **Back-to-back throughput:** response handshake in cycle R → IDLE R+1 → SETUP R+2. Minimum 4 cycles per transfer.
- **Timeout:** with PREADY stuck low, ACCESS lasts exactly `TIMEOUT_CYCLES` cycles, then RESP. PREADY arriving in the final ACCESS cycle counts as success, not timeout.
- **Empty FIFO:** IDLE stays put; bus idle.
- **Full FIFO:** `cmd_rdy_o=0` from the cycle after the push that filled it. It returns to 1 the cycle after the next pop.
- **Wrap-around:** FIFO pointers wrap modulo `FIFO_DEPTH`. Count is `$clog2(FIFO_DEPTH)+1` bits.
- **Reset mid-transfer:** at the edge with `rst_i=1`, the in-flight transfer is dropped (PSEL/PENABLE 0 next cycle), the FIFO is flushed, and no response is produced.

## Structure
- **Package `apb_master_pkg`:**
  - FSM state localparams: IDLE=0, SETUP=1, ACCESS=2, RESP=3, 2 bits.
  - Command-packing width function: 1 + BUS_AW + BUS_DW.
- **Sub-module `apb_cmd_fifo`:** synchronous FIFO with parameterized width/depth, `full`/`empty` flags, synchronous active-high reset, flop-based storage.
- **Top-level contents:** FSM, wait counter, output registers.

## Test plan
- Single write: addr 0x04, data 0xDEADBEEF, PREADY=1 → PSEL high 2 cycles, PENABLE 1 cycle with PWDATA=0xDEADBEEF; response write=1, rdata=0, timeout=0 at T+4.
- Read with 3 wait states: slave holds PREADY low 3 cycles, then returns 0x12345678 → ACCESS lasts 4 cycles; `rsp_rdata_o=0x12345678`.
- Fill FIFO: push 5 commands back-to-back with `rsp_rdy_i=0` → `cmd_rdy_o` drops after 4 accepted plus 1 in flight. Releasing `rsp_rdy_i` returns 5 responses in order.
- Timeout: `TIMEOUT_CYCLES=8`, PREADY held 0 → ACCESS exactly 8 cycles; response timeout=1, rdata=0; next command issues normally.
- Response backpressure: `rsp_rdy_i` low for 10 cycles → response fields stable and no new SETUP until the handshake.
- Reset in ACCESS with 2 commands queued → PSEL=0 next cycle, no responses, `busy_o=0`, `cmd_rdy_o=1`.
